aes_round_pipe: RTL

- Parametrised, fully pipelined run of NUM_ROUNDS consecutive AES-128 encryption rounds, one registered round per stage.
- Successor to the fixed four-round stage. Adds:
  - configurable round count;
  - optional final-round mode (no MixColumns);
  - a tag sidecar;
  - proper valid/ready back-pressure instead of a fixed-count valid pulse.
- Sits in the cohort accelerator FIFO-controller AES path. Several instances are chained to form the full cipher.

---
 rtl/aes_round_pipe.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/aes_round_pipe.sv
// Pipelined run of NUM_ROUNDS AES-128 encryption rounds, one registered round per stage,
// with a tag sidecar and a global stall on output back-pressure.

module aes_sbox (
   input  logic [7:0] a,
   output logic [7:0] y
);
   function automatic logic [7:0] gm(input logic [7:0] x, input logic [7:0] z);
      logic [7:0] p, t;
      p = 8'h00;
      t = x;
      for (int i = 0; i < 8; i++) begin
         if (z[i]) p = p ^ t;
         t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   logic [7:0] a2, a3, a6, a12, a15, a30, a60, a120, a240, a252, inv;

   // multiplicative inverse as a^254 (maps 0 to 0, as the S-box needs)
   assign a2   = gm(a, a);
   assign a3   = gm(a2, a);
   assign a6   = gm(a3, a3);
   assign a12  = gm(a6, a6);
   assign a15  = gm(a12, a3);
   assign a30  = gm(a15, a15);
   assign a60  = gm(a30, a30);
   assign a120 = gm(a60, a60);
   assign a240 = gm(a120, a120);
   assign a252 = gm(a240, a12);
   assign inv  = gm(a252, a2);

   assign y = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
            ^ {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

module aes_round_stage #(
   parameter int TAG_W    = 4,
   parameter bit SKIP_MIX = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             adv,
   input  logic             in_vld,
   input  logic [127:0]     in_data,
   input  logic [TAG_W-1:0] in_tag,
   input  logic [127:0]     key,
   output logic             vld,
   output logic [127:0]     data,
   output logic [TAG_W-1:0] tag
);
   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // element k is state byte k (byte 0 in the MSBs); byte k sits at row k%4, column k/4
   logic [0:15][7:0] st, sb, sr, mc;
   logic [127:0]     nxt;

   assign st = in_data;

   for (genvar k = 0; k < 16; k++) begin : g_sbox
      aes_sbox u_sbox (.a(st[k]), .y(sb[k]));
   end

   for (genvar c = 0; c < 4; c++) begin : g_col
      for (genvar r = 0; r < 4; r++) begin : g_row
         assign sr[4*c+r] = sb[4*((c+r)%4)+r];
         assign mc[4*c+r] = xt(sr[4*c+r]) ^ xt(sr[4*c+(r+1)%4]) ^ sr[4*c+(r+1)%4]
                          ^ sr[4*c+(r+2)%4] ^ sr[4*c+(r+3)%4];
      end
   end

   assign nxt = (SKIP_MIX ? sr : mc) ^ key;

   // payload only loads with a valid block so bubbles do not toggle the wide registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld  <= 1'b0;
         data <= '0;
         tag  <= '0;
      end else if (adv) begin
         vld <= in_vld;
         if (in_vld) begin
            data <= nxt;
            tag  <= in_tag;
         end
      end
   end
endmodule

module aes_round_pipe #(
   parameter int NUM_ROUNDS  = 4,
   parameter int FINAL_ROUND = 0,
   parameter int TAG_W       = 4
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [127:0]                      in_data,
   input  logic [TAG_W-1:0]                  in_tag,
   input  logic [128*NUM_ROUNDS-1:0]         round_keys,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [127:0]                      out_data,
   output logic [TAG_W-1:0]                  out_tag,
   output logic                              busy,
   output logic [$clog2(NUM_ROUNDS+1)-1:0]   occupancy
);
   logic                               stall, in_xfer, out_xfer;
   logic [NUM_ROUNDS:0]                vld_pipe;
   logic [NUM_ROUNDS:0][127:0]         dat_pipe;
   logic [NUM_ROUNDS:0][TAG_W-1:0]     tag_pipe;

   assign vld_pipe[0] = in_valid;
   assign dat_pipe[0] = in_data;
   assign tag_pipe[0] = in_tag;

   for (genvar g = 0; g < NUM_ROUNDS; g++) begin : g_stage
      aes_round_stage #(
         .TAG_W    (TAG_W),
         .SKIP_MIX ((FINAL_ROUND != 0) && (g == NUM_ROUNDS - 1))
      ) u_stage (
         .clk     (clk),
         .rst_n   (rst_n),
         .adv     (~stall),
         .in_vld  (vld_pipe[g]),
         .in_data (dat_pipe[g]),
         .in_tag  (tag_pipe[g]),
         .key     (round_keys[128*g +: 128]),
         .vld     (vld_pipe[g+1]),
         .data    (dat_pipe[g+1]),
         .tag     (tag_pipe[g+1])
      );
   end

   assign out_valid = vld_pipe[NUM_ROUNDS];
   assign out_data  = dat_pipe[NUM_ROUNDS];
   assign out_tag   = tag_pipe[NUM_ROUNDS];

   // whole pipe freezes only when the last stage holds a block nobody takes
   assign stall    = out_valid & ~out_ready;
   assign in_ready = ~stall;
   assign in_xfer  = in_valid & in_ready;
   assign out_xfer = out_valid & out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                     occupancy <= '0;
      else if (in_xfer && !out_xfer)  occupancy <= occupancy + 1'b1;
      else if (out_xfer && !in_xfer)  occupancy <= occupancy - 1'b1;
   end

   assign busy = |occupancy;
endmodule
